reg_scoreboard: RTL and testbench

REG_SCOREBOARD -- requirements
Module: reg_scoreboard

---
 rtl/reg_scoreboard_pkg.sv | 15 +
 rtl/reg_scoreboard_if.sv | 54 +++++
 rtl/reg_scoreboard_sb_counter.sv | 49 ++++
 rtl/reg_scoreboard.sv | 95 +++++++++
 tb/tb_reg_scoreboard.sv | 243 ++++++++++++++++++++++++
 5 files changed

// File: rtl/reg_scoreboard_pkg.sv
// ----------------------------------------------------------------------------
// reg_scoreboard_pkg
// Shared definitions for the register scoreboard slice: the architectural
// register count, the fixed codes of the implicit IMUL/MUL/DIV destination
// pair (RDX:RAX), and the register code type used on every register port.
// ----------------------------------------------------------------------------
package reg_scoreboard_pkg;

    localparam int NUM_REGS = 16;   // architectural GPR count, codes 0..15
    localparam int REG_RAX  = 0;    // low half of the implicit RDX:RAX pair
    localparam int REG_RDX  = 2;    // high half of the implicit RDX:RAX pair

    typedef logic [3:0] reg_code_t;

endpackage : reg_scoreboard_pkg

// File: rtl/reg_scoreboard_if.sv
// ----------------------------------------------------------------------------
// reg_scoreboard_if
// Groups the Read-stage issue handshake, the writeback retire bus and the
// flush request seen by the scoreboard.
//   master : Read/writeback side; drives issue, writeback and flush, and
//            observes canReadOut / issueFireOut.
//   slave  : scoreboard side; the reverse directions.
// ----------------------------------------------------------------------------
interface reg_scoreboard_if;
    import reg_scoreboard_pkg::*;

    // Issue request from the Read stage
    logic      issueValidIn;
    logic      stallIn;
    reg_code_t sourceReg1In;
    logic      sourceReg1ValidIn;
    reg_code_t sourceReg2In;
    logic      sourceReg2ValidIn;
    reg_code_t destRegIn;
    logic      destRegValidIn;
    logic      destIsSrcIn;
    logic      destRegisterSpecialValidIn;

    // Writeback retire bus
    logic      wbValidIn;
    reg_code_t wbRegIn;
    logic      wbSpecialValidIn;

    // Pipeline flush
    logic      flushIn;

    // Issue handshake results
    logic      canReadOut;
    logic      issueFireOut;

    modport master (
        output issueValidIn, stallIn,
        output sourceReg1In, sourceReg1ValidIn, sourceReg2In, sourceReg2ValidIn,
        output destRegIn, destRegValidIn, destIsSrcIn, destRegisterSpecialValidIn,
        output wbValidIn, wbRegIn, wbSpecialValidIn,
        output flushIn,
        input  canReadOut, issueFireOut
    );

    modport slave (
        input  issueValidIn, stallIn,
        input  sourceReg1In, sourceReg1ValidIn, sourceReg2In, sourceReg2ValidIn,
        input  destRegIn, destRegValidIn, destIsSrcIn, destRegisterSpecialValidIn,
        input  wbValidIn, wbRegIn, wbSpecialValidIn,
        input  flushIn,
        output canReadOut, issueFireOut
    );

endinterface : reg_scoreboard_if

// File: rtl/reg_scoreboard_sb_counter.sv
// ----------------------------------------------------------------------------
// sb_counter
// Per-register in-flight write counter. Saturates at both ends: an increment
// at all-ones holds, a decrement at zero holds and raises underflowOut for
// that cycle. A simultaneous increment and decrement cancel out. clearIn
// overrides both.
// Ports:
//   clk, reset    : clock, asynchronous active-high reset
//   incIn, decIn  : count one issued write / one retired write
//   clearIn       : synchronous clear (pipeline flush)
//   zeroOut       : counter is zero
//   fullOut       : counter is at its maximum value
//   underflowOut  : combinational pulse, decrement requested at zero
// ----------------------------------------------------------------------------
module sb_counter #(
    parameter int CNT_W = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic incIn,
    input  logic decIn,
    input  logic clearIn,
    output logic zeroOut,
    output logic fullOut,
    output logic underflowOut
);

    logic [CNT_W-1:0] count;

    assign zeroOut  = (count == '0);
    assign fullOut  = (count == '1);
    // A flushed writeback is discarded, so it cannot underflow.
    assign underflowOut = decIn && !incIn && zeroOut && !clearIn;

    // NOTE: sequential state uses non-blocking assignments only; the
    // implicit "else hold" is safe here because this is a clocked block.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (clearIn) begin
            count <= '0;
        end else if (incIn && !decIn && !fullOut) begin
            count <= count + 1'b1;
        end else if (decIn && !incIn && !zeroOut) begin
            count <= count - 1'b1;
        end
    end

endmodule : sb_counter

// File: rtl/reg_scoreboard.sv
// ----------------------------------------------------------------------------
// reg_scoreboard
// Tracks in-flight writes per architectural register and blocks issue of an
// instruction that reads a register with a pending write (RAW) or whose
// destination counter is already saturated.
// Ports:
//   clk, reset      : clock, asynchronous active-high reset
//   sbIf (slave)    : issue request, writeback retire, flush; canReadOut and
//                     issueFireOut back to the Read stage
//   busyOut         : bit i set while register i has a pending write
//   underflowErrOut : sticky, a writeback hit a register with no pending write
//   hazardCyclesOut : free-running count of cycles an issue was held by hazard
// ----------------------------------------------------------------------------
module reg_scoreboard
    import reg_scoreboard_pkg::reg_code_t;
    import reg_scoreboard_pkg::REG_RAX;
    import reg_scoreboard_pkg::REG_RDX;
#(
    parameter int CNT_W    = 2,
    parameter int NUM_REGS = reg_scoreboard_pkg::NUM_REGS
) (
    input  logic                clk,
    input  logic                reset,
    reg_scoreboard_if.slave     sbIf,
    output logic [NUM_REGS-1:0] busyOut,
    output logic                underflowErrOut,
    output logic [31:0]         hazardCyclesOut
);

    logic [NUM_REGS-1:0] targeted;     // registers this instruction writes
    logic [NUM_REGS-1:0] readUse;      // registers this instruction reads
    logic [NUM_REGS-1:0] retire;       // registers retired by writeback
    logic [NUM_REGS-1:0] zeroVec;
    logic [NUM_REGS-1:0] fullVec;
    logic [NUM_REGS-1:0] underflowVec;
    logic                hazard;
    logic                issueFire;

    for (genvar i = 0; i < NUM_REGS; i++) begin : gReg
        localparam reg_code_t CODE       = reg_code_t'(i);
        localparam bit        IS_SPECIAL = (i == REG_RAX) || (i == REG_RDX);

        // Expressed as one-hot vectors so RAX/RDX named both explicitly and
        // implicitly still count once.
        assign targeted[i] = (sbIf.destRegValidIn && (sbIf.destRegIn == CODE))
                          || (sbIf.destRegisterSpecialValidIn && IS_SPECIAL);

        assign readUse[i]  = (sbIf.sourceReg1ValidIn && (sbIf.sourceReg1In == CODE))
                          || (sbIf.sourceReg2ValidIn && (sbIf.sourceReg2In == CODE))
                          || (sbIf.destIsSrcIn       && (sbIf.destRegIn    == CODE));

        assign retire[i]   = (sbIf.wbValidIn && (sbIf.wbRegIn == CODE))
                          || (sbIf.wbSpecialValidIn && IS_SPECIAL);

        sb_counter #(
            .CNT_W (CNT_W)
        ) uCounter (
            .clk          (clk),
            .reset        (reset),
            .incIn        (issueFire && targeted[i]),
            .decIn        (retire[i]),
            .clearIn      (sbIf.flushIn),
            .zeroOut      (zeroVec[i]),
            .fullOut      (fullVec[i]),
            .underflowOut (underflowVec[i])
        );
    end

    assign busyOut = ~zeroVec;

    // Hazard uses registered counter state only, so a writeback in this
    // cycle frees a register starting next cycle (no bypass).
    assign hazard = |(readUse & busyOut) || |(targeted & fullVec);

    // NOTE: purely combinational outputs are continuous assigns, so no path
    // can leave a value unassigned and infer a latch.
    assign sbIf.canReadOut   = sbIf.issueValidIn && !hazard && !sbIf.flushIn;
    assign issueFire         = sbIf.canReadOut && !sbIf.stallIn;
    assign sbIf.issueFireOut = issueFire;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            underflowErrOut <= 1'b0;
            hazardCyclesOut <= '0;
        end else begin
            if (|underflowVec) begin
                underflowErrOut <= 1'b1;
            end
            if (sbIf.issueValidIn && hazard && !sbIf.flushIn) begin
                hazardCyclesOut <= hazardCyclesOut + 32'd1;
            end
        end
    end

endmodule : reg_scoreboard

// File: tb/tb_reg_scoreboard.sv
// ----------------------------------------------------------------------------
// tb_reg_scoreboard
// Directed bench for reg_scoreboard with default parameters (CNT_W=2,
// NUM_REGS=16). Inputs change 1 time unit after a rising edge; outputs are
// sampled a further time unit later.
// ----------------------------------------------------------------------------
module tb_reg_scoreboard;

    logic        clk;
    logic        reset;
    logic [15:0] busy;
    logic        underflowErr;
    logic [31:0] hazardCycles;
    int          total = 0;
    int          bad   = 0;

    reg_scoreboard_if busIf ();

    reg_scoreboard dut (
        .clk             (clk),
        .reset           (reset),
        .sbIf            (busIf.slave),
        .busyOut         (busy),
        .underflowErrOut (underflowErr),
        .hazardCyclesOut (hazardCycles)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        total++;
        assert (observed === expected)
        else begin
            bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        busIf.issueValidIn               = 1'b0;
        busIf.stallIn                    = 1'b0;
        busIf.sourceReg1In               = '0;
        busIf.sourceReg1ValidIn          = 1'b0;
        busIf.sourceReg2In               = '0;
        busIf.sourceReg2ValidIn          = 1'b0;
        busIf.destRegIn                  = '0;
        busIf.destRegValidIn             = 1'b0;
        busIf.destIsSrcIn                = 1'b0;
        busIf.destRegisterSpecialValidIn = 1'b0;
        busIf.wbValidIn                  = 1'b0;
        busIf.wbRegIn                    = '0;
        busIf.wbSpecialValidIn           = 1'b0;
        busIf.flushIn                    = 1'b0;
    endtask

    initial begin
        // ---------------- reset state ----------------
        idle();
        reset = 1'b1;
        #12;
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_underflow", 32'(underflowErr), 32'h0);
        check("rst_hazcyc", hazardCycles, 32'h0);
        busIf.issueValidIn = 1'b1;
        #1;
        check("rst_canread", 32'(busIf.canReadOut), 32'h1);
        busIf.flushIn = 1'b1;
        #1;
        check("rst_canread_flush", 32'(busIf.canReadOut), 32'h0);
        idle();
        #1;
        reset = 1'b0;
        tick();

        // ---------------- RAW on reg 3 ----------------
        busIf.issueValidIn   = 1'b1;
        busIf.destRegValidIn = 1'b1;
        busIf.destRegIn      = 4'd3;
        #1;
        check("raw3_issue_canread", 32'(busIf.canReadOut), 32'h1);
        check("raw3_issue_fire", 32'(busIf.issueFireOut), 32'h1);
        tick();
        busIf.destRegValidIn    = 1'b0;
        busIf.sourceReg1ValidIn = 1'b1;
        busIf.sourceReg1In      = 4'd3;
        #1;
        check("raw3_busy", 32'(busy), 32'h0008);
        check("raw3_stall_canread", 32'(busIf.canReadOut), 32'h0);
        check("raw3_stall_fire", 32'(busIf.issueFireOut), 32'h0);
        tick();
        check("raw3_hazcyc1", hazardCycles, 32'd1);
        tick();
        check("raw3_hazcyc2", hazardCycles, 32'd2);
        busIf.wbValidIn = 1'b1;
        busIf.wbRegIn   = 4'd3;
        #1;
        check("raw3_no_bypass", 32'(busIf.canReadOut), 32'h0);
        tick();
        busIf.wbValidIn = 1'b0;
        #1;
        check("raw3_after_wb_canread", 32'(busIf.canReadOut), 32'h1);
        check("raw3_after_wb_busy", 32'(busy), 32'h0);
        check("raw3_hazcyc3", hazardCycles, 32'd3);
        idle();

        // ---------------- implicit RDX:RAX destination ----------------
        busIf.issueValidIn               = 1'b1;
        busIf.destRegisterSpecialValidIn = 1'b1;
        #1;
        check("imul_issue_canread", 32'(busIf.canReadOut), 32'h1);
        tick();
        busIf.destRegisterSpecialValidIn = 1'b0;
        busIf.sourceReg2ValidIn          = 1'b1;
        busIf.sourceReg2In               = 4'd2;
        #1;
        check("imul_busy", 32'(busy), 32'h0005);
        check("imul_stall", 32'(busIf.canReadOut), 32'h0);
        tick();
        check("imul_still_stall", 32'(busIf.canReadOut), 32'h0);
        busIf.wbSpecialValidIn = 1'b1;
        tick();
        busIf.wbSpecialValidIn = 1'b0;
        #1;
        check("imul_wb_busy", 32'(busy), 32'h0);
        check("imul_wb_canread", 32'(busIf.canReadOut), 32'h1);
        check("imul_hazcyc", hazardCycles, 32'd5);
        idle();

        // ---------------- saturation on reg 5 ----------------
        busIf.issueValidIn   = 1'b1;
        busIf.destRegValidIn = 1'b1;
        busIf.destRegIn      = 4'd5;
        #1;
        check("sat5_fire1", 32'(busIf.issueFireOut), 32'h1);
        tick();
        check("sat5_fire2", 32'(busIf.issueFireOut), 32'h1);
        tick();
        check("sat5_fire3", 32'(busIf.issueFireOut), 32'h1);
        tick();
        check("sat5_full_canread", 32'(busIf.canReadOut), 32'h0);
        check("sat5_busy", 32'(busy), 32'h0020);
        tick();
        check("sat5_hazcyc", hazardCycles, 32'd6);
        busIf.wbValidIn = 1'b1;
        busIf.wbRegIn   = 4'd5;
        #1;
        check("sat5_wb_no_bypass", 32'(busIf.canReadOut), 32'h0);
        tick();
        busIf.wbValidIn = 1'b0;
        #1;
        check("sat5_fourth_fire", 32'(busIf.issueFireOut), 32'h1);
        check("sat5_hazcyc2", hazardCycles, 32'd7);
        tick();
        idle();

        // ---------------- same-cycle issue and writeback on reg 7 ----------------
        busIf.issueValidIn   = 1'b1;
        busIf.destRegValidIn = 1'b1;
        busIf.destRegIn      = 4'd7;
        tick();
        check("same7_busy_before", 32'(busy), 32'h00A0);
        busIf.wbValidIn = 1'b1;
        busIf.wbRegIn   = 4'd7;
        #1;
        check("same7_fire", 32'(busIf.issueFireOut), 32'h1);
        tick();
        check("same7_busy_after", 32'(busy), 32'h00A0);
        busIf.issueValidIn = 1'b0;
        tick();
        check("same7_retired", 32'(busy), 32'h0020);
        idle();

        // ---------------- downstream stall blocks the increment ----------------
        busIf.issueValidIn   = 1'b1;
        busIf.stallIn        = 1'b1;
        busIf.destRegValidIn = 1'b1;
        busIf.destRegIn      = 4'd4;
        #1;
        check("stall_canread", 32'(busIf.canReadOut), 32'h1);
        check("stall_fire", 32'(busIf.issueFireOut), 32'h0);
        tick();
        check("stall_busy", 32'(busy), 32'h0020);
        idle();

        // ---------------- underflow on reg 9 ----------------
        busIf.wbValidIn = 1'b1;
        busIf.wbRegIn   = 4'd9;
        tick();
        busIf.wbValidIn = 1'b0;
        #1;
        check("uf9_err", 32'(underflowErr), 32'h1);
        check("uf9_busy", 32'(busy), 32'h0020);

        // ---------------- flush overrides issue and writeback ----------------
        busIf.issueValidIn   = 1'b1;
        busIf.destRegValidIn = 1'b1;
        busIf.destRegIn      = 4'd5;
        busIf.flushIn        = 1'b1;
        #1;
        check("flush_canread", 32'(busIf.canReadOut), 32'h0);
        tick();
        idle();
        #1;
        check("flush_busy", 32'(busy), 32'h0);
        check("flush_keeps_err", 32'(underflowErr), 32'h1);
        check("flush_hazcyc", hazardCycles, 32'd7);

        // ---------------- reset mid-stall ----------------
        busIf.issueValidIn   = 1'b1;
        busIf.destRegValidIn = 1'b1;
        busIf.destRegIn      = 4'd1;
        tick();
        busIf.destRegValidIn    = 1'b0;
        busIf.sourceReg1ValidIn = 1'b1;
        busIf.sourceReg1In      = 4'd1;
        tick();
        check("midrst_pre_hazcyc", hazardCycles, 32'd8);
        check("midrst_pre_busy", 32'(busy), 32'h0002);
        #2;
        reset = 1'b1;
        #1;
        check("midrst_busy", 32'(busy), 32'h0);
        check("midrst_hazcyc", hazardCycles, 32'h0);
        check("midrst_err", 32'(underflowErr), 32'h0);
        check("midrst_canread", 32'(busIf.canReadOut), 32'h1);
        #1;
        reset = 1'b0;
        tick();
        check("postrst_busy", 32'(busy), 32'h0);
        check("postrst_canread", 32'(busIf.canReadOut), 32'h1);
        idle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_reg_scoreboard
